// File: rtl/morse_keyer.sv
// morse_keyer: sequences one Morse character (dots/dashes plus gaps) onto the
// key output, using an external unit timer that is restarted via unit_clear.
//
// Handshake: a character is accepted on any rising edge where start=1 and
// ready=1; ready stays low until the trailing gap ends (char_done pulse) or an
// abort returns the block to idle. start while ready=0 is ignored.
module morse_keyer #(
  parameter int MAXLEN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] sym_bits,
  input  logic [2:0] sym_len,
  input  logic       word_end,
  input  logic       abort,
  input  logic       unit_done,
  output logic       unit_clear,
  output logic       key,
  output logic       ready,
  output logic       char_done,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  localparam logic [2:0] MAX_L = 3'(MAXLEN);

  state_t     state_q;
  logic [4:0] bits_q;
  logic [2:0] len_q;
  logic       word_q;
  logic [2:0] idx_q;
  logic [2:0] ucnt_q;
  logic       key_q;
  logic       ready_q;
  logic       uclr_q;
  logic       done_q;

  logic [2:0] len_d;
  logic       unit_end;
  logic       mark_last;
  logic       more_elems;
  logic       trail_last;

  // Decode unit boundaries and end-of-element conditions from the latched pattern.
  always_comb begin
    len_d      = (sym_len > MAX_L) ? MAX_L : sym_len;
    // The timer's done flag is stale while it is being cleared.
    unit_end   = unit_done && !uclr_q;
    mark_last  = bits_q[idx_q] ? (ucnt_q == 3'd2) : (ucnt_q == 3'd0);
    more_elems = (idx_q + 3'd1) < len_q;
    trail_last = word_q ? (ucnt_q == 3'd6) : (ucnt_q == 3'd2);
  end

  // Element sequencer with registered key/ready/unit_clear/char_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bits_q  <= 5'd0;
      len_q   <= 3'd0;
      word_q  <= 1'b0;
      idx_q   <= 3'd0;
      ucnt_q  <= 3'd0;
      key_q   <= 1'b0;
      ready_q <= 1'b1;
      uclr_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        key_q   <= 1'b0;
        ready_q <= 1'b1;
        uclr_q  <= 1'b1;
        if (start) begin
          bits_q  <= sym_bits;
          len_q   <= len_d;
          idx_q   <= 3'd0;
          ucnt_q  <= 3'd0;
          ready_q <= 1'b0;
          // unit_clear stays high one more cycle to open the first unit.
          if (len_d != 3'd0) begin
            word_q  <= word_end;
            key_q   <= 1'b1;
            state_q <= S_MARK;
          end else begin
            word_q  <= 1'b1;
            key_q   <= 1'b0;
            state_q <= S_TRAIL;
          end
        end
      end else if (abort) begin
        state_q <= S_IDLE;
        key_q   <= 1'b0;
        ready_q <= 1'b1;
        uclr_q  <= 1'b1;
      end else if (unit_end) begin
        // Each unit boundary restarts the timer with a single clear cycle.
        uclr_q <= 1'b1;
        if (state_q == S_MARK) begin
          if (mark_last) begin
            ucnt_q  <= 3'd0;
            key_q   <= 1'b0;
            state_q <= more_elems ? S_SPACE : S_TRAIL;
          end else begin
            ucnt_q <= ucnt_q + 3'd1;
          end
        end else if (state_q == S_SPACE) begin
          idx_q   <= idx_q + 3'd1;
          key_q   <= 1'b1;
          state_q <= S_MARK;
        end else begin
          if (trail_last) begin
            ucnt_q  <= 3'd0;
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            ucnt_q <= ucnt_q + 3'd1;
          end
        end
      end else begin
        uclr_q <= 1'b0;
      end
    end
  end

  assign unit_clear  = uclr_q;
  assign key         = key_q;
  assign ready       = ready_q;
  assign char_done   = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: unit timer model with U = 8 clocks and a per-cycle
// reference waveform built from Morse timing rules.
module tb_morse_keyer;

  localparam int U = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] sym_bits;
  logic [2:0] sym_len;
  logic       word_end;
  logic       abort;
  logic       unit_done;
  logic       unit_clear;
  logic       key;
  logic       ready;
  logic       char_done;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // {key, unit_clear, char_done, ready} expected per cycle
  logic [3:0] exp_q[$];

  logic [2:0] tcnt;

  morse_keyer #(.MAXLEN(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sym_bits    (sym_bits),
    .sym_len     (sym_len),
    .word_end    (word_end),
    .abort       (abort),
    .unit_done   (unit_done),
    .unit_clear  (unit_clear),
    .key         (key),
    .ready       (ready),
    .char_done   (char_done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit timer: cleared while unit_clear=1, done after 7 running cycles.
  // The done flag stays high through the clear cycle (stale).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 3'd7;
    else if (unit_clear) tcnt <= 3'd0;
    else if (tcnt != 3'd7) tcnt <= tcnt + 3'd1;
  end
  assign unit_done = (tcnt >= 3'd6);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Build expected waveform from Morse rules, then compare every cycle.
  // Caller has already raised start at the current negedge.
  task automatic run_char(input logic [4:0] b, input logic [2:0] l, input logic w,
                          input bit noise, input bit chain,
                          input logic [4:0] nb, input logic [2:0] nl, input logic nw);
    int n;
    int len_c;
    logic [3:0] got;
    logic [3:0] e;
    bit wave[$];
    len_c = (int'(l) > 5) ? 5 : int'(l);
    for (int i = 0; i < len_c; i++) begin
      repeat ((b[i] ? 3 : 1) * U) wave.push_back(1'b1);
      if (i < len_c - 1) repeat (U) wave.push_back(1'b0);
    end
    repeat ((((len_c == 0) || w) ? 7 : 3) * U) wave.push_back(1'b0);
    n = wave.size();
    for (int j = 0; j < n; j++) exp_q.push_back({wave[j], ((j % U) == 0), 1'b0, 1'b0});
    exp_q.push_back(4'b0111);
    for (int j = 0; j <= n; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      got = {key, unit_clear, char_done, ready};
      e = exp_q.pop_front();
      check($sformatf("char_len%0d_j%0d", len_c, j), 32'(got), 32'(e));
      if (noise && j == n / 2) begin
        start    = 1'b1;
        sym_bits = ~b;
        sym_len  = 3'($urandom_range(0, 7));
        word_end = ~w;
      end
      if (noise && j == n / 2 + 1) start = 1'b0;
      if (chain && j == n) begin
        start    = 1'b1;
        sym_bits = nb;
        sym_len  = nl;
        word_end = nw;
      end
    end
  endtask

  task automatic drive_start(input logic [4:0] b, input logic [2:0] l, input logic w);
    @(negedge clk);
    sym_bits = b;
    sym_len  = l;
    word_end = w;
    start    = 1'b1;
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] cb, nb;
    logic [2:0] cl, nl;
    logic       cw, nw;
    bit         chain;

    rst_n = 1'b0; start = 1'b0; sym_bits = 5'd0; sym_len = 3'd0;
    word_end = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_key", 32'(key), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_uclr", 32'(unit_clear), 32'd1);
    check("rst_done", 32'(char_done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 'A'
    drive_start(5'b00010, 3'd2, 1'b0);
    run_char(5'b00010, 3'd2, 1'b0, 0, 0, 5'd0, 3'd0, 1'b0);
    // 'T' with word gap
    drive_start(5'b00001, 3'd1, 1'b1);
    run_char(5'b00001, 3'd1, 1'b1, 0, 0, 5'd0, 3'd0, 1'b0);
    // word space only
    drive_start(5'b10101, 3'd0, 1'b0);
    run_char(5'b10101, 3'd0, 1'b0, 0, 0, 5'd0, 3'd0, 1'b0);
    // clamped length: 5 dashes
    drive_start(5'b11111, 3'd7, 1'b0);
    run_char(5'b11111, 3'd7, 1'b0, 0, 0, 5'd0, 3'd0, 1'b0);

    // abort 10 clocks into a dash
    drive_start(5'b00001, 3'd1, 1'b0);
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
    end
    check("abort_pre_key", 32'(key), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_key", 32'(key), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_uclr", 32'(unit_clear), 32'd1);
    check("abort_done", 32'(char_done), 32'd0);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      check("abort_idle_done", 32'(char_done), 32'd0);
      check("abort_idle_key", 32'(key), 32'd0);
    end
    drive_start(5'b00010, 3'd2, 1'b0);
    run_char(5'b00010, 3'd2, 1'b0, 0, 0, 5'd0, 3'd0, 1'b0);

    // busy start and pattern changes ignored; then back-to-back 'E','E'
    drive_start(5'b00110, 3'd4, 1'b0);
    run_char(5'b00110, 3'd4, 1'b0, 1, 0, 5'd0, 3'd0, 1'b0);
    drive_start(5'b00000, 3'd1, 1'b0);
    run_char(5'b00000, 3'd1, 1'b0, 0, 1, 5'b00000, 3'd1, 1'b0);
    run_char(5'b00000, 3'd1, 1'b0, 0, 0, 5'd0, 3'd0, 1'b0);

    // reset in the middle of MARK
    drive_start(5'b00001, 3'd1, 1'b0);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
    end
    check("mrst_pre_key", 32'(key), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_key", 32'(key), 32'd0);
    check("mrst_ready", 32'(ready), 32'd1);
    check("mrst_uclr", 32'(unit_clear), 32'd1);
    check("mrst_done", 32'(char_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_idle_ready", 32'(ready), 32'd1);
    check("mrst_idle_key", 32'(key), 32'd0);
    drive_start(5'b00000, 3'd1, 1'b0);
    run_char(5'b00000, 3'd1, 1'b0, 0, 0, 5'd0, 3'd0, 1'b0);

    // randomized characters, some chained, some with busy-time noise
    nb = 5'($urandom_range(0, 31));
    nl = 3'($urandom_range(0, 7));
    nw = 1'($urandom_range(0, 1));
    drive_start(nb, nl, nw);
    for (int i = 0; i < 16; i++) begin
      cb = nb; cl = nl; cw = nw;
      nb = 5'($urandom_range(0, 31));
      nl = 3'($urandom_range(0, 7));
      nw = 1'($urandom_range(0, 1));
      chain = (i < 15) && ($urandom_range(0, 1) == 1);
      run_char(cb, cl, cw, ($urandom_range(0, 1) == 1), chain, nb, nl, nw);
      if (!chain && i < 15) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        drive_start(nb, nl, nw);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
# morse_keyer

Morse element sequencer for the encoder datapath. It accepts one character as a dot/dash pattern and drives the key output with standard Morse unit timing. Unit duration comes from the external unit timer, which is cleared through `unit_clear` and reports expiry on `unit_done`. The block sits between the character-to-code lookup (upstream) and the key/LED output.

## Interface

Parameters:
- `MAXLEN`, 5, maximum elements per character; `sym_len` values above this are clamped.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `sym_bits`  in  5  element pattern; bit 0 is sent first; 1 = dash, 0 = dot.
- `sym_len`  in  3  element count; 0 = word space only.
- `word_end`  in  1  trailing gap is 7 units instead of 3.
- `abort`  in  1  synchronous cancel of the current character.
- `unit_done`  in  1  unit timer expired.
- `unit_clear`  out  1  holds or restarts the unit timer.
- `key`  out  1  Morse key, 1 = tone or mark.
- `ready`  out  1  idle and able to accept `start`.
- `char_done`  out  1  one-cycle pulse when the character, including its trailing gap, is complete.

## Operation

- All outputs are registered. Reset values: `key`=0, `ready`=1, `unit_clear`=1, `char_done`=0.
- States:
  - IDLE
  - MARK (key=1)
  - SPACE (key=0, 1-unit intra-character gap)
  - TRAIL (key=0, 3 or 7 units)
- IDLE:
  - `ready`=1 and `unit_clear` is held at 1.
  - On `start`, latch `sym_bits`, `min(sym_len,MAXLEN)` and `word_end`. Clear the element index and the 3-bit unit counter. Drop `ready`.
  - If length ≥ 1, go to MARK. If length = 0, go to TRAIL with a forced 7-unit gap.
- Unit boundaries:
  - Every unit begins with exactly one cycle of `unit_clear`=1.
  - A unit ends on the first cycle with `unit_done`=1 while `unit_clear`=0.
  - `unit_done` is ignored while `unit_clear`=1, because the timer's done flag is stale during clear.
- MARK: lasts 1 unit for a dot or 3 units for a dash, counted by the unit counter.
  - At the end, if more elements remain, go to SPACE.
  - Otherwise go to TRAIL.
- SPACE: after 1 unit, increment the element index and go to MARK.
- TRAIL: after 3 units (or 7 if `word_end`, or if length = 0):
  - Return to IDLE.
  - Pulse `char_done` for one cycle.
  - Set `ready`=1 and set `unit_clear`=1.
- `abort`, in any non-IDLE state:
  - At the next edge, go to IDLE.
  - Set `key`=0, `ready`=1, `unit_clear`=1.
  - No `char_done` pulse.
  - `abort` has priority over `unit_done`.
- `start` while `ready`=0 is ignored. Latched pattern values are not affected by input changes mid-character.
- Reset mid-character drives every output to its reset value immediately (asynchronously). The latched pattern is discarded.

## Timing

- Start edge (IDLE with `start`=1):
  - `key` takes the value of the first state at that edge: 1 for MARK, 0 for a length-0 character.
  - `unit_clear` stays 1 for exactly one further cycle, then drops.
- Unit-end edge: the `key` change and the `unit_clear` rise occur at the same edge. `unit_clear` falls one edge later.
- Unit length U = number of clocks from one `unit_clear` rise to the next. U is fixed by the timer. The keyer adds no extra cycles beyond the one clear cycle per unit.
- Character duration: sum(mark units) + (len−1) + trail units, times U.
- `char_done` and `ready` rise at the edge that ends the last trail unit. A `start` in the same cycle as the `char_done` pulse is accepted on the next edge, which gives back-to-back characters with no dead unit.

## Test plan

Bench timer model gives U = 8 clocks.

1. 'A' (`sym_len`=2, `sym_bits`=5'b00010, `word_end`=0) → `key` high 8, low 8, high 24, low 24. `char_done` pulses 64 clocks after start. Exactly 8 `unit_clear` pulses.
2. 'T' (`sym_len`=1, `sym_bits`=1, `word_end`=1) → `key` high 24, low 56. `char_done` at 80 clocks.
3. `sym_len`=0 → `key` stays 0 for 56 clocks, then `char_done`. `sym_len`=7, `sym_bits`=5'b11111 → treated as 5 dashes, 5·24 + 4·8 + 24 = 176 clocks.
4. `abort` asserted 10 clocks into a dash → next edge `key`=0, `ready`=1, `unit_clear`=1, no `char_done`. A new `start` then runs normally.
5. `start` pulsed while busy, plus `sym_bits` changed mid-character → no effect on the sequence. Back-to-back 'E','E' with `start` during `char_done` → second mark begins on the following edge.
6. `rst_n` low in the middle of MARK → `key`=0, `ready`=1, `unit_clear`=1, `char_done`=0 immediately. After release, block is idle and a fresh 'E' gives 8 high, 24 low.
